// File: rtl/uart_ram_dump_if.sv
`default_nettype none
//==============================================================================
// Module  : uart_ram_dump_if
// Purpose : Start/status, RAM read-port and serial-line signals of the RAM dumper.
// Revision: 1.0 - initial release
//==============================================================================
interface uart_ram_dump_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  start;
  logic                  ram_grant;
  logic [7:0]            rdata;
  logic                  ask_for_ram;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  serial_txd;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, ram_grant, rdata,
    output ask_for_ram, raddr, serial_txd, busy, done
  );

  modport slave (
    output start, ram_grant, rdata,
    input  ask_for_ram, raddr, serial_txd, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/uart_ram_dump.sv
`default_nettype none
//==============================================================================
// Module  : uart_ram_dump
// Purpose : 8N1 UART dump of a RAM window: sync byte, data bytes, 8-bit checksum.
// Revision: 1.0 - initial release
//==============================================================================
module uart_ram_dump #(
  parameter int                    CLK_HZ     = 25125000,
  parameter int                    BAUD       = 57600,
  parameter int                    ADDR_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] DUMP_START = 11'h200,
  parameter int                    DUMP_LEN   = 1024,
  parameter logic [7:0]            SYNC_BYTE  = 8'hA5
) (
  input  wire logic        clk,
  input  wire logic        reset,
  uart_ram_dump_if.master  bus
);

  localparam int c_DIV    = CLK_HZ / BAUD;
  localparam int c_BAUD_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_IDX_W  = (DUMP_LEN > 0) ? $clog2(DUMP_LEN + 1) : 1;

  localparam logic [c_BAUD_W-1:0] c_DIV_LAST = c_BAUD_W'(c_DIV - 1);
  localparam logic [c_IDX_W-1:0]  c_LEN      = c_IDX_W'(DUMP_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_REQ   = 3'd2,
    S_LATCH = 3'd3,
    S_DATA  = 3'd4,
    S_SUM   = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t                r_state;
  logic [7:0]            r_shift;
  logic [3:0]            r_bit;
  logic [c_BAUD_W-1:0]   r_baud;
  logic [c_IDX_W-1:0]    r_index;
  logic [7:0]            r_sum;
  logic [ADDR_WIDTH-1:0] r_raddr;

  state_t                w_state_nxt;
  logic [7:0]            w_shift_nxt;
  logic [3:0]            w_bit_nxt;
  logic [c_BAUD_W-1:0]   w_baud_nxt;
  logic [c_IDX_W-1:0]    w_index_nxt;
  logic [7:0]            w_sum_nxt;
  logic [ADDR_WIDTH-1:0] w_raddr_nxt;

  logic                  w_tx_active;
  logic                  w_bit_end;
  logic                  w_frame_end;
  logic [2:0]            w_bit_idx;

  assign w_tx_active = (r_state == S_SYNC) || (r_state == S_DATA) || (r_state == S_SUM);
  assign w_bit_end   = (r_baud == c_DIV_LAST);
  assign w_frame_end = w_bit_end && (r_bit == 4'd9);
  // r_bit counts start(0), data(1..8), stop(9); data bit n sits at r_bit n+1
  assign w_bit_idx   = 3'(r_bit - 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_baud  <= '0;
      r_index <= '0;
      r_sum   <= '0;
      r_raddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_baud  <= w_baud_nxt;
      r_index <= w_index_nxt;
      r_sum   <= w_sum_nxt;
      r_raddr <= w_raddr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_baud_nxt  = r_baud;
    w_index_nxt = r_index;
    w_sum_nxt   = r_sum;
    w_raddr_nxt = r_raddr;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_SYNC;
          w_shift_nxt = SYNC_BYTE;
          w_bit_nxt   = '0;
          w_baud_nxt  = '0;
        end
      end
      S_SYNC, S_DATA, S_SUM: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          w_bit_nxt  = r_bit + 4'd1;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
        if (w_frame_end) begin
          w_bit_nxt = '0;
          if (r_state == S_SUM) begin
            w_state_nxt = S_FIN;
          end else if (r_index != c_LEN) begin
            w_state_nxt = S_REQ;
            w_raddr_nxt = DUMP_START + ADDR_WIDTH'(r_index);
          end else begin
            w_state_nxt = S_SUM;
            w_shift_nxt = r_sum;
          end
        end
      end
      S_REQ: begin
        if (bus.ram_grant) begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        // RAM output was registered on the grant edge, so it is valid here
        w_shift_nxt = bus.rdata;
        w_sum_nxt   = r_sum + bus.rdata;
        w_index_nxt = r_index + 1'b1;
        w_state_nxt = S_DATA;
      end
      S_FIN: begin
        w_sum_nxt   = '0;
        w_index_nxt = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.serial_txd = 1'b1;
    if (w_tx_active) begin
      if (r_bit == 4'd0) begin
        bus.serial_txd = 1'b0;
      end else if (r_bit == 4'd9) begin
        bus.serial_txd = 1'b1;
      end else begin
        bus.serial_txd = r_shift[w_bit_idx];
      end
    end
  end

  assign bus.ask_for_ram = (r_state == S_REQ) || (r_state == S_LATCH);
  assign bus.raddr       = r_raddr;
  assign bus.busy        = (r_state != S_IDLE) && (r_state != S_FIN);
  assign bus.done        = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_uart_ram_dump.sv
`default_nettype none
//==============================================================================
// Module  : tb_uart_ram_dump
// Purpose : Directed bench: line decoder, RAM model, wrap/stall/reset scenarios.
// Revision: 1.0 - initial release
//==============================================================================
module tb_uart_ram_dump;

  localparam int DIV_M = 436;
  localparam int DIV_Z = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_ram_dump_if #(.ADDR_WIDTH(11)) u_if ();
  uart_ram_dump_if #(.ADDR_WIDTH(11)) u_if0 ();

  uart_ram_dump #(
    .ADDR_WIDTH (11),
    .DUMP_START (11'h7FE),
    .DUMP_LEN   (3)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.master)
  );

  uart_ram_dump #(
    .CLK_HZ     (1000),
    .BAUD       (100),
    .ADDR_WIDTH (11),
    .DUMP_START (11'h200),
    .DUMP_LEN   (0)
  ) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if0.master)
  );

  logic [7:0]  mem [0:2047];
  int          done_cnt  = 0;
  int          done0_cnt = 0;
  int          ask0_cnt  = 0;
  logic        prev_ask  = 1'b0;
  logic [10:0] raddr_q [$];

  always @(posedge clk) begin
    if (u_if.ram_grant) u_if.rdata <= mem[u_if.raddr];
  end

  always @(negedge clk) begin
    if (u_if.done === 1'b1) done_cnt++;
    if (u_if0.done === 1'b1) done0_cnt++;
    if (u_if0.ask_for_ram === 1'b1) ask0_cnt++;
    if (u_if.ask_for_ram === 1'b1 && prev_ask !== 1'b1) raddr_q.push_back(u_if.raddr);
    prev_ask = u_if.ask_for_ram;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic txd_of(input bit sel);
    return sel ? u_if0.serial_txd : u_if.serial_txd;
  endfunction

  // Called at a negedge; samples each bit at its midpoint relative to the first low sample.
  task automatic rx_byte(input bit sel, input int div, output logic [7:0] b,
                         output logic stopb, output int lowlen);
    int   n;
    bit   seen;
    bit   low_run;
    logic s;
    b = '0; stopb = 1'bx; lowlen = 0; seen = 0; n = 0;
    while (!seen && n < 10000) begin
      if (txd_of(sel) === 1'b0) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("rx_start_seen", 32'(seen), 32'd1);
    if (seen) begin
      low_run = 1;
      for (int t = 0; t <= 9*div + div/2; t++) begin
        if (t > 0) @(negedge clk);
        s = txd_of(sel);
        if (low_run && s === 1'b0) lowlen++;
        else low_run = 0;
        for (int i = 1; i <= 8; i++) if (t == i*div + div/2) b[i-1] = s;
        if (t == 9*div + div/2) stopb = s;
      end
    end
  endtask

  task automatic rx_expect(input bit sel, input int div, input string tag, input logic [7:0] exp);
    logic [7:0] b;
    logic       stopb;
    int         lowlen;
    rx_byte(sel, div, b, stopb, lowlen);
    check(tag, 32'(b), 32'(exp));
    check({tag, "_stop"}, 32'(stopb), 32'd1);
  endtask

  task automatic wait_done(input bit sel, input int target, input int bound, input string tag);
    int n = 0;
    while ((sel ? done0_cnt : done_cnt) < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check(tag, 32'(sel ? done0_cnt : done_cnt), 32'(target));
  endtask

  task automatic wait_ask(input string tag);
    int n = 0;
    while (u_if.ask_for_ram !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(u_if.ask_for_ram), 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    logic       stopb;
    int         lowlen;
    int         viol;
    int         dc;

    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    reset = 1'b1;
    u_if.start = 1'b0;  u_if.ram_grant = 1'b0;  u_if.rdata = 8'h00;
    u_if0.start = 1'b0; u_if0.ram_grant = 1'b0; u_if0.rdata = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_ask",   32'(u_if.ask_for_ram), 32'd0);
    check("rst_raddr", 32'(u_if.raddr),       32'd0);
    check("rst_txd",   32'(u_if.serial_txd),  32'd1);
    check("rst_busy",  32'(u_if.busy),        32'd0);
    check("rst_done",  32'(u_if.done),        32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Empty window: sync then zero checksum
    u_if0.start = 1'b1;
    @(negedge clk);
    u_if0.start = 1'b0;
    check("z_busy", 32'(u_if0.busy), 32'd1);
    rx_expect(1'b1, DIV_Z, "z_sync", 8'hA5);
    rx_expect(1'b1, DIV_Z, "z_sum",  8'h00);
    wait_done(1'b1, 1, 2*DIV_Z, "z_done_cnt");
    check("z_busy_after", 32'(u_if0.busy), 32'd0);
    check("z_no_ask",     32'(ask0_cnt),   32'd0);

    // Grant tied high, wrapping window 7FE,7FF,000
    mem[11'h7FE] = 8'h01; mem[11'h7FF] = 8'h02; mem[11'h000] = 8'h03;
    u_if.ram_grant = 1'b1;
    raddr_q.delete();
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    check("b_busy", 32'(u_if.busy), 32'd1);
    rx_byte(1'b0, DIV_M, b, stopb, lowlen);
    check("b_sync",      32'(b),      32'hA5);
    check("b_sync_stop", 32'(stopb),  32'd1);
    check("b_bit_width", 32'(lowlen), 32'd436);
    rx_expect(1'b0, DIV_M, "b_d0",  8'h01);
    rx_expect(1'b0, DIV_M, "b_d1",  8'h02);
    rx_expect(1'b0, DIV_M, "b_d2",  8'h03);
    rx_expect(1'b0, DIV_M, "b_sum", 8'h06);
    wait_done(1'b0, 1, 2*DIV_M, "b_done_cnt");
    check("b_busy_after", 32'(u_if.busy),  32'd0);
    check("b_raddr_n",    32'(raddr_q.size()), 32'd3);
    if (raddr_q.size() == 3) begin
      check("b_raddr0", 32'(raddr_q[0]), 32'h7FE);
      check("b_raddr1", 32'(raddr_q[1]), 32'h7FF);
      check("b_raddr2", 32'(raddr_q[2]), 32'h000);
    end

    // Stalled grant, repeated start, grant dropped in LATCH, checksum wrap
    mem[11'h7FE] = 8'hFF; mem[11'h7FF] = 8'hFF; mem[11'h000] = 8'h03;
    u_if.ram_grant = 1'b0;
    raddr_q.delete();
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    rx_expect(1'b0, DIV_M, "c_sync", 8'hA5);
    wait_ask("c_ask_rise");
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      u_if.start = (i == 3);
      if (u_if.ask_for_ram !== 1'b1 || u_if.serial_txd !== 1'b1) viol++;
      @(negedge clk);
    end
    u_if.start = 1'b0;
    check("c_stall_viol", 32'(viol),        32'd0);
    check("c_stall_addr", 32'(u_if.raddr),  32'h7FE);
    u_if.ram_grant = 1'b1;
    @(negedge clk);
    u_if.ram_grant = 1'b0;
    rx_expect(1'b0, DIV_M, "c_d0", 8'hFF);
    u_if.ram_grant = 1'b1;
    rx_expect(1'b0, DIV_M, "c_d1",  8'hFF);
    rx_expect(1'b0, DIV_M, "c_d2",  8'h03);
    rx_expect(1'b0, DIV_M, "c_sum", 8'h01);
    wait_done(1'b0, 2, 2*DIV_M, "c_done_cnt");
    check("c_raddr_n", 32'(raddr_q.size()), 32'd3);

    // Reset during a data byte
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    rx_expect(1'b0, DIV_M, "d_sync", 8'hA5);
    viol = 0;
    while (u_if.serial_txd !== 1'b0 && viol < 4000) begin
      @(negedge clk);
      viol++;
    end
    check("d_data_start", 32'(u_if.serial_txd), 32'd0);
    repeat (100) @(negedge clk);
    dc = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("d_rst_txd",  32'(u_if.serial_txd),  32'd1);
    check("d_rst_busy", 32'(u_if.busy),        32'd0);
    check("d_rst_ask",  32'(u_if.ask_for_ram), 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2*DIV_M) @(negedge clk);
    check("d_no_done",   32'(done_cnt),        32'(dc));
    check("d_idle_txd",  32'(u_if.serial_txd), 32'd1);
    check("d_idle_busy", 32'(u_if.busy),       32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
